// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the ALU / mul-div unit.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Opcodes follow the MIPS R-type funct field (LUI borrows an unused slot).
   localparam logic [5:0] OP_SLL   = 6'h00;
   localparam logic [5:0] OP_SRL   = 6'h02;
   localparam logic [5:0] OP_SRA   = 6'h03;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_MFHI  = 6'h10;
   localparam logic [5:0] OP_MTHI  = 6'h11;
   localparam logic [5:0] OP_MFLO  = 6'h12;
   localparam logic [5:0] OP_MTLO  = 6'h13;
   localparam logic [5:0] OP_MULT  = 6'h18;
   localparam logic [5:0] OP_MULTU = 6'h19;
   localparam logic [5:0] OP_DIV   = 6'h1A;
   localparam logic [5:0] OP_DIVU  = 6'h1B;
   localparam logic [5:0] OP_ADD   = 6'h20;
   localparam logic [5:0] OP_ADDU  = 6'h21;
   localparam logic [5:0] OP_SUB   = 6'h22;
   localparam logic [5:0] OP_SUBU  = 6'h23;
   localparam logic [5:0] OP_AND   = 6'h24;
   localparam logic [5:0] OP_OR    = 6'h25;
   localparam logic [5:0] OP_XOR   = 6'h26;
   localparam logic [5:0] OP_NOR   = 6'h27;
   localparam logic [5:0] OP_SLT   = 6'h2A;
   localparam logic [5:0] OP_SLTU  = 6'h2B;

endpackage

// File: rtl/mdu_iter.sv
// Bit-serial shift-add multiplier and restoring divider sharing one {acc, sh} register
// pair and one down-counter; signed ops run on magnitudes and are sign-fixed on output.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_div,
   input  logic             is_signed,
   output logic             last,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic             b_zero_q, b_zero_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;

   always_comb begin
      acc_d    = acc_q;
      sh_d     = sh_q;
      dvs_d    = dvs_q;
      a_d      = a_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      b_zero_d = b_zero_q;

      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;

      mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : '0);
      div_shift = {acc_q, sh_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, dvs_q};

      if (load) begin
         acc_d    = '0;
         sh_d     = a_mag;
         dvs_d    = b_mag;
         a_d      = a;
         cnt_d    = CW'(WIDTH);
         is_div_d = is_div;
         neg_q_d  = a_neg ^ b_neg;
         neg_r_d  = a_neg;
         b_zero_d = (b == '0);
      end else if (step && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (is_div_q) begin
            // Borrow out of the trial subtract means the divisor did not fit.
            if (!div_diff[WIDTH]) begin
               acc_d = div_diff[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = div_shift[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         sh_q     <= '0;
         dvs_q    <= '0;
         a_q      <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         b_zero_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         sh_q     <= sh_d;
         dvs_q    <= dvs_d;
         a_q      <= a_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         b_zero_q <= b_zero_d;
      end
   end

   assign last = (cnt_q == '0);

   logic [2*WIDTH-1:0] prod, prod_fix;

   always_comb begin
      prod     = {acc_q, sh_q};
      prod_fix = neg_q_q ? -prod : prod;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         // Divide by zero reports all-ones quotient and the untouched dividend.
         if (b_zero_q) begin
            res_lo = '1;
            res_hi = a_q;
         end else begin
            res_lo = neg_q_q ? -sh_q : sh_q;
            res_hi = neg_r_q ? -acc_q : acc_q;
         end
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// ALU with combinational ops plus HI/LO registers fed by the iterative mul/div unit.
//   state   | meaning
//   IDLE    | waiting; MTHI/MTLO and mul/div accept allowed
//   RUN     | mdu_iter stepping WIDTH bits, then one commit cycle into hi/lo
//   FIN     | result committed, done pulses
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   aluop,
   input  logic             start,
   output logic [WIDTH-1:0] c,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             is_mul, is_div, is_signed, is_mdu;
   logic             mdu_load, mdu_step, mdu_last;
   logic [WIDTH-1:0] mdu_hi, mdu_lo;

   logic [WIDTH-1:0] sum, diff;
   logic [SHW-1:0]   shamt;

   assign is_mul    = (aluop == OPW'(OP_MULT)) || (aluop == OPW'(OP_MULTU));
   assign is_div    = (aluop == OPW'(OP_DIV))  || (aluop == OPW'(OP_DIVU));
   assign is_signed = (aluop == OPW'(OP_MULT)) || (aluop == OPW'(OP_DIV));
   assign is_mdu    = is_mul || is_div;

   mdu_iter #(.WIDTH(WIDTH)) u_mdu (
      .clk       (clk),
      .rst       (rst),
      .load      (mdu_load),
      .step      (mdu_step),
      .a         (a),
      .b         (b),
      .is_div    (is_div),
      .is_signed (is_signed),
      .last      (mdu_last),
      .res_hi    (mdu_hi),
      .res_lo    (mdu_lo)
   );

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mdu_load = 1'b0;
      mdu_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && is_mdu) begin
               mdu_load = 1'b1;
               state_d  = ST_RUN;
            end else if (start && aluop == OPW'(OP_MTHI)) begin
               hi_d = a;
            end else if (start && aluop == OPW'(OP_MTLO)) begin
               lo_d = a;
            end
         end
         ST_RUN: begin
            if (mdu_last) begin
               hi_d    = mdu_hi;
               lo_d    = mdu_lo;
               state_d = ST_FIN;
            end else begin
               mdu_step = 1'b1;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_FIN);
   assign hi   = hi_q;
   assign lo   = lo_q;

   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = a[SHW-1:0];

   always_comb begin
      c        = '0;
      overflow = 1'b0;
      case (aluop)
         OPW'(OP_ADDU): c = sum;
         OPW'(OP_SUBU): c = diff;
         OPW'(OP_ADD): begin
            c        = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OPW'(OP_SUB): begin
            c        = diff;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OPW'(OP_AND):  c = a & b;
         OPW'(OP_OR):   c = a | b;
         OPW'(OP_XOR):  c = a ^ b;
         OPW'(OP_NOR):  c = ~(a | b);
         OPW'(OP_SLT):  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OPW'(OP_SLTU): c = {{(WIDTH-1){1'b0}}, (a < b)};
         OPW'(OP_LUI):  c = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OPW'(OP_SLL):  c = b << shamt;
         OPW'(OP_SRL):  c = b >> shamt;
         OPW'(OP_SRA):  c = $unsigned($signed(b) >>> shamt);
         OPW'(OP_MFHI): c = hi_q;
         OPW'(OP_MFLO): c = lo_q;
         default:       c = '0;
      endcase
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: combinational ops, HI/LO moves, mul/div timing and corner cases.
module tb_alu_mdu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] a, b, c, hi, lo;
   logic [5:0]  aluop;
   logic        start, overflow, busy, done;

   logic [15:0] a16, b16, c16, hi16, lo16;
   logic [5:0]  aluop16;
   logic        start16, overflow16, busy16, done16;

   int errors = 0;
   int checks = 0;
   int n;
   int ndone;

   alu_mdu #(.WIDTH(32), .OPW(6)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .aluop(aluop), .start(start),
      .c(c), .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   alu_mdu #(.WIDTH(16), .OPW(6)) dut16 (
      .clk(clk), .rst(rst), .a(a16), .b(b16), .aluop(aluop16), .start(start16),
      .c(c16), .overflow(overflow16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic comb(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
      aluop = op;
      a     = av;
      b     = bv;
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
      aluop = op;
      a     = av;
      b     = bv;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (done !== 1'b1 && cnt < 60) begin
         tick;
         cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; aluop = OP_SLL;
      start16 = 1'b0; a16 = '0; b16 = '0; aluop16 = OP_SLL;
      tick;
      tick;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      rst = 1'b0;
      tick;

      comb(OP_ADD, 32'h7FFFFFFF, 32'd1);
      chk("add_c", c, 32'h80000000);
      chk("add_ovf", 32'(overflow), 32'd1);
      comb(OP_ADDU, 32'h7FFFFFFF, 32'd1);
      chk("addu_c", c, 32'h80000000);
      chk("addu_ovf", 32'(overflow), 32'd0);
      comb(OP_SUB, 32'h80000000, 32'd1);
      chk("sub_c", c, 32'h7FFFFFFF);
      chk("sub_ovf", 32'(overflow), 32'd1);
      comb(OP_SUBU, 32'd5, 32'd7);
      chk("subu_c", c, 32'hFFFFFFFE);
      chk("subu_ovf", 32'(overflow), 32'd0);
      comb(OP_AND, 32'hF0F01234, 32'h0FF000FF);
      chk("and", c, 32'h00F00034);
      comb(OP_OR, 32'hF0F01234, 32'h0FF000FF);
      chk("or", c, 32'hFFF012FF);
      comb(OP_XOR, 32'hF0F01234, 32'h0FF000FF);
      chk("xor", c, 32'hFF0012CB);
      comb(OP_NOR, 32'hF0F01234, 32'h0FF000FF);
      chk("nor", c, 32'h000FED00);
      comb(OP_SLT, 32'hFFFFFFFF, 32'd1);
      chk("slt", c, 32'd1);
      comb(OP_SLTU, 32'hFFFFFFFF, 32'd1);
      chk("sltu", c, 32'd0);
      comb(OP_LUI, 32'd0, 32'h1234ABCD);
      chk("lui", c, 32'hABCD0000);
      comb(OP_SLL, 32'd31, 32'd1);
      chk("sll", c, 32'h80000000);
      comb(OP_SRL, 32'h24, 32'h80000000);
      chk("srl_amt_mask", c, 32'h08000000);
      comb(OP_SRA, 32'd4, 32'h80000000);
      chk("sra", c, 32'hF8000000);
      comb(6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("undef_c", c, 32'h0);
      chk("undef_ovf", 32'(overflow), 32'd0);

      issue(OP_MTHI, 32'h1111, 32'h0);
      chk("mthi_hi", hi, 32'h1111);
      chk("mthi_busy", 32'(busy), 32'd0);
      chk("mthi_done", 32'(done), 32'd0);
      issue(OP_MTLO, 32'h2222, 32'h0);
      chk("mtlo_lo", lo, 32'h2222);
      chk("mtlo_hi_kept", hi, 32'h1111);
      comb(OP_MFHI, 32'h0, 32'h0);
      chk("mfhi", c, 32'h1111);
      comb(OP_MFLO, 32'h0, 32'h0);
      chk("mflo", c, 32'h2222);

      issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
      comb(OP_MFHI, 32'h0, 32'h0);
      chk("busy_mfhi_old", c, 32'h1111);
      chk("busy_flag", 32'(busy), 32'd1);
      comb(OP_ADD, 32'd2, 32'd3);
      chk("busy_add", c, 32'd5);
      wait_done(n);
      chk("mult_latency", 32'(n), 32'd33);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFF1);
      tick;
      chk("after_fin_done", 32'(done), 32'd0);
      chk("after_fin_busy", 32'(busy), 32'd0);

      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(n);
      chk("multu_latency", 32'(n), 32'd33);
      chk("multu_hi", hi, 32'hFFFFFFFE);
      chk("multu_lo", lo, 32'h00000001);
      tick;

      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done(n);
      chk("div_latency", 32'(n), 32'd33);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);
      tick;

      issue(OP_DIVU, 32'd7, 32'd0);
      wait_done(n);
      chk("divu0_latency", 32'(n), 32'd33);
      chk("divu0_lo", lo, 32'hFFFFFFFF);
      chk("divu0_hi", hi, 32'd7);
      tick;

      issue(OP_DIV, 32'hFFFFFFFB, 32'd0);
      wait_done(n);
      chk("div0_neg_lo", lo, 32'hFFFFFFFF);
      chk("div0_neg_hi", hi, 32'hFFFFFFFB);
      tick;

      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done(n);
      chk("div_minneg_lo", lo, 32'h80000000);
      chk("div_minneg_hi", hi, 32'h0);
      tick;

      issue(OP_MULT, 32'd6, 32'd7);
      ndone = 0;
      for (int i = 1; i <= 45; i++) begin
         if (i == 5) begin
            start = 1'b1; aluop = OP_DIV; a = 32'd100; b = 32'd3;
         end else if (i == 8) begin
            start = 1'b1; aluop = OP_MTHI; a = 32'hDEAD;
         end else begin
            start = 1'b0; aluop = OP_ADD; a = 32'd9; b = 32'd9;
         end
         tick;
         if (done === 1'b1) ndone++;
         if (i == 8) chk("mthi_busy_ignored", hi, 32'h0);
      end
      start = 1'b0;
      chk("nostack_done_count", 32'(ndone), 32'd1);
      chk("nostack_hi", hi, 32'h0);
      chk("nostack_lo", lo, 32'd42);

      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (9) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (done === 1'b1) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_lo_kept", lo, 32'h0);

      aluop16 = OP_ADD; a16 = 16'h7FFF; b16 = 16'h0001;
      #1;
      chk("w16_add_c", 32'(c16), 32'h8000);
      chk("w16_add_ovf", 32'(overflow16), 32'd1);
      aluop16 = OP_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
      tick;
      start16 = 1'b0;
      chk("w16_busy", 32'(busy16), 32'd1);
      n = 0;
      while (done16 !== 1'b1 && n < 60) begin
         tick;
         n++;
      end
      chk("w16_latency", 32'(n), 32'd17);
      chk("w16_hi", 32'(hi16), 32'hFFFE);
      chk("w16_lo", 32'(lo16), 32'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits (≥8, even).
REQ-002 SHALL provide parameter OPW, default 6, aluop field width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port a  input  WIDTH  operand A (rs).
REQ-006 SHALL have port b  input  WIDTH  operand B (rt/immediate).
REQ-007 SHALL have port aluop  input  OPW  operation select.
REQ-008 SHALL have port start  input  1  request for the mul/div/move-to-HI/LO op on aluop.
REQ-009 SHALL have port c  output  WIDTH  combinational result.
REQ-010 SHALL have port overflow  output  1  signed-overflow flag for ADD/SUB.
REQ-011 SHALL have port busy  output  1  iterative operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when an iterative result is committed.
REQ-013 SHALL have ports hi, lo  output  WIDTH each  HI/LO register contents.

Function
REQ-014 Combinational ops SHALL be ADDU, SUBU, ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, LUI ({b[WIDTH/2-1:0], zeros}), SLL/SRL/SRA (shift b by a[log2(WIDTH)-1:0]), MFHI (c=hi), MFLO (c=lo).
REQ-015 Any unlisted aluop SHALL drive c=0; c SHALL never infer a latch.
REQ-016 overflow SHALL be 1 only for ADD/SUB when signed result overflows; 0 for all other ops.
REQ-017 Iterative ops SHALL be MULT, MULTU, DIV, DIVU; accepted only when start=1 and busy=0.
REQ-018 FSM SHALL have states IDLE, RUN, FIN; IDLE->RUN on accept; RUN->FIN after exactly WIDTH iteration cycles; FIN->IDLE unconditionally.
REQ-019 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-020 done SHALL pulse in FIN; hi/lo SHALL update at the same edge that enters FIN, giving visible results WIDTH+1 cycles after the accept edge.
REQ-021 Operands SHALL be latched at accept; later changes to a/b/aluop SHALL NOT affect the result.
REQ-022 start while busy=1 SHALL be ignored (no queueing).
REQ-023 MULT/MULTU SHALL produce the 2*WIDTH-bit product: hi=upper half, lo=lower half.
REQ-024 DIV/DIVU SHALL give lo=quotient and hi=remainder; signed quotient SHALL truncate toward zero and remainder SHALL take the dividend's sign.
REQ-025 Divide by zero SHALL complete with normal timing and give lo=all ones, hi=a.
REQ-026 Signed DIV of most-negative by -1 SHALL give lo=most-negative and hi=0.
REQ-027 MTHI/MTLO with start=1 and busy=0 SHALL write a into hi/lo at the next edge with no busy and no done; when busy=1 they SHALL be ignored.
REQ-028 Combinational ops SHALL stay usable while busy; MFHI/MFLO while busy SHALL return the previous committed value.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, busy=0, done=0, hi=0, lo=0, internal iteration registers=0.
REQ-030 rst SHALL have priority over start and abort any RUN/FIN operation without committing hi/lo.

Structure
REQ-031 Opcode constants and FSM state encodings SHALL live in shared package alu_pkg, replacing per-file defines.
REQ-032 The shift-add multiplier and restoring divider SHALL sit in one sub-module, mdu_iter (one bit per cycle, shared counter); the ALU top SHALL hold combinational ops, the FSM and hi/lo.

Verification
REQ-033 ADD a=0x7FFFFFFF, b=1 -> c=0x80000000, overflow=1; ADDU with same operands -> overflow=0.
REQ-034 MULT a=-3 (0xFFFFFFFD), b=5 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 Start MULT, pulse start with DIV at cycle 5, change a/b mid-run -> one done only, with the original MULT result.
REQ-037 Assert rst at cycle 10 of a DIV -> busy=0, hi=lo=0 next cycle, and no done pulse.
REQ-038 WIDTH=16 instance: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001, done 17 cycles after accept.
